// File: rtl/multicycle_control_if.sv
// Control-path bundle between the multicycle main FSM and the shared datapath.
// Latency: wires only, no storage.
// Backpressure: the datapath memory stalls the FSM through mem_ready; nothing else throttles.
//
// Signals (direction as seen by the controller, modport master):
//   in : opcode[5:0]  IR[31:26], valid from DECODE onward
//   in : zero         ALU Zero flag (datapath gates pc_write_cond with it)
//   in : mem_ready    memory completes the current access this cycle
//   out: pc_write, pc_write_cond, pc_source[1:0], i_or_d, mem_read, mem_write,
//        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//        alu_op[1:0], instr_done, illegal_op, bus_error, state[3:0], instr_count[31:0]
interface multicycle_control_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_source;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        instr_done;
    logic        illegal_op;
    logic        bus_error;
    logic [3:0]  state;
    logic [31:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal_op, bus_error, state, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal_op, bus_error, state, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle CPU: sequences FETCH/DECODE/EXECUTE/MEM/WB over one shared ALU/memory/regfile.
// Latency (mem_ready=1): R-type 4, lw 5, sw 4, addi 4, beq 3, j 3 cycles; illegal opcode 2 cycles.
// Backpressure: FETCH/MEM_READ/MEM_WRITE hold until mem_ready; after WAIT_LIMIT idle cycles a bus_error aborts to FETCH.
//
// Ports: clk, reset (synchronous, active-high; all outputs forced to 0 while high),
//        bus (multicycle_control_if.master: opcode/zero/mem_ready in, datapath controls out).
// Optional: define MULTICYCLE_INSTR_COUNT_EN to build the 32-bit retired-instruction counter;
//           otherwise instr_count is tied to 0.
// CNT_W must satisfy 2**CNT_W > WAIT_LIMIT so the counter can reach the limit.
module multicycle_control #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_WB   = 4'd9,
        S_JUMP      = 4'd10
    } state_t;

    // Memory-path instructions share MEM_ADDR; the class picks the branch out of it.
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_LW   = 2'd1,
        CLS_SW   = 2'd2,
        CLS_ADDI = 2'd3
    } op_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
        logic       bus_error;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q, state_d;
    op_class_t        cls_q, cls_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    ctrl_t            ctrl, ctrl_o;
    logic             wait_expired;
    logic             unused_zero;

    // The Zero flag is consumed by the datapath's PC-load gate, not here.
    assign unused_zero = bus.zero;

    // mem_ready in the limit cycle takes priority, so expiry requires it low.
    assign wait_expired = !bus.mem_ready && (wait_q == CNT_W'(WAIT_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
        end
    end

    // wait_d defaults to 0: any state change, any mem_ready and any timeout clears it.
    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        cls_d   = cls_q;
        wait_d  = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = S_DECODE;
                end else if (wait_expired) begin
                    // PC untouched, so staying in FETCH retries the same address.
                    ctrl.bus_error = 1'b1;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                cls_d          = CLS_NONE;
                case (bus.opcode)
                    OP_RTYPE: state_d = S_EXECUTE;
                    OP_LW: begin
                        cls_d   = CLS_LW;
                        state_d = S_MEM_ADDR;
                    end
                    OP_SW: begin
                        cls_d   = CLS_SW;
                        state_d = S_MEM_ADDR;
                    end
                    OP_ADDI: begin
                        cls_d   = CLS_ADDI;
                        state_d = S_MEM_ADDR;
                    end
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    default: begin
                        ctrl.illegal_op = 1'b1;
                        state_d         = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                case (cls_q)
                    CLS_LW:   state_d = S_MEM_READ;
                    CLS_SW:   state_d = S_MEM_WRITE;
                    CLS_ADDI: state_d = S_ADDI_WB;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (wait_expired) begin
                    ctrl.bus_error = 1'b1;
                    state_d        = S_FETCH;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl.i_or_d = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.mem_write  = 1'b1;
                    ctrl.instr_done = 1'b1;
                    state_d         = S_FETCH;
                end else if (wait_expired) begin
                    // Write strobe dropped so the aborted store cannot land.
                    ctrl.bus_error = 1'b1;
                    state_d        = S_FETCH;
                end else begin
                    ctrl.mem_write = 1'b1;
                    wait_d         = wait_q + CNT_W'(1);
                end
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b10;
                state_d        = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.instr_done    = 1'b1;
                state_d            = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = 2'b10;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks everything combinationally so no write escapes in the reset cycle itself.
    assign ctrl_o = reset ? '0 : ctrl;

    assign bus.pc_write      = ctrl_o.pc_write;
    assign bus.pc_write_cond = ctrl_o.pc_write_cond;
    assign bus.pc_source     = ctrl_o.pc_source;
    assign bus.i_or_d        = ctrl_o.i_or_d;
    assign bus.mem_read      = ctrl_o.mem_read;
    assign bus.mem_write     = ctrl_o.mem_write;
    assign bus.ir_write      = ctrl_o.ir_write;
    assign bus.mem_to_reg    = ctrl_o.mem_to_reg;
    assign bus.reg_dst       = ctrl_o.reg_dst;
    assign bus.reg_write     = ctrl_o.reg_write;
    assign bus.alu_src_a     = ctrl_o.alu_src_a;
    assign bus.alu_src_b     = ctrl_o.alu_src_b;
    assign bus.alu_op        = ctrl_o.alu_op;
    assign bus.instr_done    = ctrl_o.instr_done;
    assign bus.illegal_op    = ctrl_o.illegal_op;
    assign bus.bus_error     = ctrl_o.bus_error;
    assign bus.state         = reset ? 4'd0 : state_q;

`ifdef MULTICYCLE_INSTR_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (ctrl.instr_done) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign bus.instr_count = reset ? 32'd0 : count_q;
`else
    assign bus.instr_count = 32'd0;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy main control FSM for the multi-cycle CPU variant. A single ALU, memory port and register file are shared across cycles.
- Decodes a 6-bit opcode and sequences the instruction through FETCH/DECODE/EXECUTE/MEM/WB. Drives ALUSrcA/ALUSrcB/ALUOp (ALUOp consumed by the existing ALU-control decode: 00 add, 01 sub/compare, 10 funct), plus memory, IR, PC and register-file enables.
- Waits on a memory-ready handshake with a bounded timeout.

Parameters:
- WAIT_LIMIT, 15: max consecutive cycles to wait for mem_ready in any memory state before abort.
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- opcode  input  6  IR[31:26], valid from DECODE onward.
- zero  input  1  ALU Zero flag (meaningful only with ALUOp=01).
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if zero.
- pc_source  output  2  00 ALU result, 01 ALUOut reg, 10 jump target.
- i_or_d  output  1  0 = PC address, 1 = ALUOut address.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load.
- mem_to_reg  output  1  write-back source is MDR.
- reg_dst  output  1  1 = rd, 0 = rt.
- reg_write  output  1  register-file write.
- alu_src_a  output  1  0 = PC, 1 = rs.
- alu_src_b  output  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- alu_op  output  2  to ALU control.
- instr_done  output  1  one-cycle pulse on the last cycle of each retired instruction.
- illegal_op  output  1  one-cycle pulse, unknown opcode.
- bus_error  output  1  one-cycle pulse, mem_ready timeout.
- state  output  4  current state, for debug.
- instr_count  output  32  retired-instruction count (see Optional Feature).

Behaviour:
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE, 6 EXECUTE, 7 R_WB, 8 BRANCH, 9 ADDI_WB, 10 JUMP.
  - 11–15 unused; any of these goes to FETCH next cycle with all outputs 0.
- Reset:
  - While reset=1, all outputs are 0.
  - Next state is FETCH; wait counter is 0.
  - Reset in any state aborts the instruction with no further writes.
- Defaults: every output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - If mem_ready: ir_write=1, pc_write=1, pc_source=00, go to DECODE.
  - Else stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 000000 → EXECUTE
    - 100011 or 101011 → MEM_ADDR
    - 000100 → BRANCH
    - 001000 → MEM_ADDR with addi flag
    - 000010 → JUMP
    - other → FETCH with illegal_op=1
  - Implementation: latch a 2-bit op class at DECODE.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: lw → MEM_READ; sw → MEM_WRITE; addi → ADDI_WB.
- MEM_READ:
  - Outputs: mem_read=1, i_or_d=1.
  - mem_ready → MEM_WB; else stay.
- MEM_WB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
  - Next state: FETCH.
- MEM_WRITE:
  - Outputs: mem_write=1, i_or_d=1.
  - mem_ready → instr_done=1, go to FETCH; else stay.
- EXECUTE:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state: R_WB.
- R_WB:
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1.
  - Next state: FETCH.
- ADDI_WB:
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
  - Next state: FETCH.
- JUMP:
  - Outputs: pc_write=1, pc_source=10, instr_done=1.
  - Next state: FETCH.
- Wait counter:
  - Applies in FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle mem_ready=0; clears on mem_ready=1 or on any state change.
  - When the counter equals WAIT_LIMIT and mem_ready=0: bus_error=1 for that cycle, all write enables 0, go to FETCH, counter cleared.
  - FETCH timeout leaves the PC unchanged (retry).
  - mem_ready=1 in the limit cycle wins over the timeout.
- Latency with mem_ready tied to 1:
  - R-type 4, lw 5, sw 4, addi 4, beq 3, j 3 cycles.
  - Illegal opcode takes 2 cycles with no instr_done.

Optional Feature:
- Macro: MULTICYCLE_INSTR_COUNT_EN.
- Defined:
  - instr_count is a 32-bit register, cleared by reset.
  - Increments by 1 on each cycle with instr_done=1; wraps 0xFFFFFFFF → 0.
- Undefined: instr_count is tied to 0; no register is synthesized.

Test Plan:
- Reset held 3 cycles mid-MEM_READ → all outputs 0 during reset; state=0 on the first cycle after release; no reg_write.
- mem_ready=1, opcode=000000 → states 0,1,6,7; alu_op=10 in state 6; reg_write=1 and reg_dst=1 in cycle 4; one instr_done pulse.
- lw (100011) with mem_ready low for 3 cycles in MEM_READ → state sequence 0,1,2,3,3,3,3,4,0; mem_to_reg=1 in state 4.
- beq (000100) → states 0,1,8; alu_op=01, pc_write_cond=1, pc_source=01 in state 8; next state 0.
- opcode=111111 → illegal_op pulse in DECODE; state 0 next; no write enables; instr_count unchanged.
- mem_ready=0 for 20 cycles in FETCH, WAIT_LIMIT=15 → bus_error pulse in cycle 16; pc_write=0 throughout; FETCH restarts with the counter cleared.
- With MULTICYCLE_INSTR_COUNT_EN, run j, addi, sw → instr_count=3.
